// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// counter sizing helper and radix-2 Booth recode patterns.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // {Q[0], q_1} patterns that trigger a subtract or an add of M
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  // Bits needed to hold values 0 .. n-1; the step counter is sized with clog2(WIDTH+2)
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into the
// accumulator followed by an arithmetic right shift of {acc, q, q_1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] q,
  input  logic           q_1,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] acc_next,
  output logic [WIDTH:0] q_next,
  output logic           q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      BOOTH_SUB: sum = acc - m;
      BOOTH_ADD: sum = acc + m;
      default:   sum = acc;
    endcase
    // Shift keeps the accumulator sign bit; accumulator LSB moves into q
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, with a fixed
// WIDTH+1 step latency and a start/busy/done handshake.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             is_signed,
  input  logic             start_operation,
  output logic             busy,
  output logic             stop_operation,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Handshake: a start is taken only while the FSM is IDLE (busy covers
  // RUN, FINISH and the done cycle); stop_operation is a single-cycle pulse
  // and HI/LO are valid from that cycle until the next result or reset.

  localparam int CW = clog2(WIDTH + 2);

  state_t         state;
  state_t         state_next;
  logic [WIDTH:0] acc;
  logic [WIDTH:0] q;
  logic           q_1;
  logic [WIDTH:0] m;
  logic [CW-1:0]  count;

  logic [WIDTH:0] acc_nx;
  logic [WIDTH:0] q_nx;
  logic           q_1_nx;

  logic           accept;
  logic           step_en;
  logic           load_result;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .acc_next (acc_nx),
    .q_next   (q_nx),
    .q_1_next (q_1_nx)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_operation) state_next = RUN;
      RUN:     if (count == CW'(WIDTH)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == IDLE) && start_operation;
    step_en     = (state == RUN);
    load_result = (state == FINISH);
    // The done cycle has state IDLE already, so it is folded into busy here
    busy        = (state != IDLE) || stop_operation;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m     <= '0;
      count <= '0;
    end else if (accept) begin
      acc   <= '0;
      q     <= {is_signed & in_A[WIDTH-1], in_A};
      q_1   <= 1'b0;
      m     <= {is_signed & in_B[WIDTH-1], in_B};
      count <= '0;
    end else if (step_en) begin
      acc   <= acc_nx;
      q     <= q_nx;
      q_1   <= q_1_nx;
      count <= count + CW'(1);
    end
  end

  // Product {acc, q} is 2*WIDTH+2 bits; the low 2*WIDTH bits are the result
  always_ff @(posedge clk) begin
    if (!reset) begin
      HI             <= '0;
      LO             <= '0;
      stop_operation <= 1'b0;
    end else begin
      stop_operation <= load_result;
      if (load_result) begin
        HI <= {acc[WIDTH-2:0], q[WIDTH]};
        LO <= q[WIDTH-1:0];
      end
    end
  end

endmodule
